lut_cfg_sched: RTL and testbench



---
 rtl/lut_pkg.sv | 18 +
 rtl/lut_cfg_sched_if.sv | 31 +++
 rtl/lut_shadow_buf.sv | 27 ++
 rtl/lut_cfg_sched.sv | 116 +++++++++++
 tb/tb_lut_cfg_sched.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_pkg.sv
// Shared constants and FSM state type for the LUT configuration scheduler.
package lut_pkg;
  localparam int NUM_LUTS  = 16;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_WIDTH = 4;
  localparam int CFG_W     = 32;
  localparam int BUS_W     = 4096;
  localparam int IMG_W     = NUM_LUTS * LUT_DEPTH * LUT_WIDTH;
  localparam int WORDS     = IMG_W / CFG_W;
  localparam int WCNT_W    = $clog2(WORDS);
  localparam int GEN_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;
endpackage

// File: rtl/lut_cfg_sched_if.sv
// Config stream, lookup request/result and lut_bank signals of lut_cfg_sched.
interface lut_cfg_sched_if;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [lut_pkg::CFG_W-1:0]     cfg_data;
  logic                          cfg_last;
  logic                          lk_valid;
  logic                          lk_ready;
  logic [lut_pkg::BUS_W-1:0]     lk_data;
  logic                          res_valid;
  logic                          res_ready;
  logic [lut_pkg::BUS_W-1:0]     res_data;
  logic                          lb_cfg_update;
  logic                          lb_lut_wr_valid;
  logic [lut_pkg::BUS_W-1:0]     lb_in_weights;
  logic [lut_pkg::BUS_W-1:0]     lb_out_weights;
  logic [lut_pkg::GEN_W-1:0]     lut_gen;
  logic                          cfg_err;

  modport master (
    output cfg_valid, cfg_data, cfg_last, lk_valid, lk_data, res_ready, lb_out_weights,
    input  cfg_ready, lk_ready, res_valid, res_data, lb_cfg_update, lb_lut_wr_valid,
           lb_in_weights, lut_gen, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, lk_valid, lk_data, res_ready, lb_out_weights,
    output cfg_ready, lk_ready, res_valid, res_data, lb_cfg_update, lb_lut_wr_valid,
           lb_in_weights, lut_gen, cfg_err
  );
endinterface

// File: rtl/lut_shadow_buf.sv
// Shadow LUT image: one register per config word, written by word index, read out flat.
module lut_shadow_buf
  import lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WCNT_W-1:0] wr_idx,
  input  logic [CFG_W-1:0]  wr_data,
  output logic [IMG_W-1:0]  rd_data
);
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [CFG_W-1:0] word_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= '0;
        end else if (wr_en && (wr_idx == WCNT_W'(gi))) begin
          word_q <= wr_data;
        end
      end

      assign rd_data[gi*CFG_W +: CFG_W] = word_q;
    end
  endgenerate
endmodule

// File: rtl/lut_cfg_sched.sv
// LUT image loader, commit arbiter and lookup result stage in front of lut_bank.
// Framing checks on cfg_last are built only when LUT_CFG_CHECK_EN is defined.
module lut_cfg_sched
  import lut_pkg::*;
(
  input logic            clk,
  input logic            rst,
  lut_cfg_sched_if.slave bus
);
  localparam logic [1:0]        ST_IDLE   = IDLE;
  localparam logic [1:0]        ST_LOAD   = LOAD;
  localparam logic [1:0]        ST_COMMIT = COMMIT;
  localparam logic [WCNT_W-1:0] LAST_IDX  = WCNT_W'(WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic              res_valid_q;
  logic [BUS_W-1:0]  res_data_q;
  logic [GEN_W-1:0]  gen_q;
  logic              commit;
  logic              cfg_fire;
  logic              lk_fire;
  logic              shadow_wr;
  logic [IMG_W-1:0]  shadow;

  lut_shadow_buf u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_wr),
    .wr_idx  (wcnt_q),
    .wr_data (bus.cfg_data),
    .rd_data (shadow)
  );

  // The commit cycle owns the bank bus, so both input streams stall for it.
  assign commit        = (state_q == ST_COMMIT);
  assign bus.cfg_ready = rdy_q && !commit;
  assign bus.lk_ready  = !commit && (!res_valid_q || bus.res_ready);
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign lk_fire       = bus.lk_valid && bus.lk_ready;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    shadow_wr = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (cfg_fire) begin
          shadow_wr = 1'b1;
          wcnt_d    = wcnt_q + 1'b1;
          state_d   = (wcnt_q == LAST_IDX) ? ST_COMMIT : ST_LOAD;
`ifdef LUT_CFG_CHECK_EN
          if (bus.cfg_last && (wcnt_q != LAST_IDX)) begin
            err_d   = 1'b1;
            wcnt_d  = '0;
            state_d = ST_IDLE;
          end else if (!bus.cfg_last && (wcnt_q == LAST_IDX)) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

`ifndef LUT_CFG_CHECK_EN
  logic unused_cfg_last;
  assign unused_cfg_last = bus.cfg_last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      gen_q       <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (lk_fire) begin
        res_valid_q <= 1'b1;
        res_data_q  <= bus.lb_out_weights;
      end else if (bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
      if (commit) begin
        gen_q <= gen_q + 1'b1;
      end
    end
  end

  // Strobes are gated by rst so a reset landing on the commit cycle never loads the bank.
  assign bus.lb_cfg_update   = commit && !rst;
  assign bus.lb_lut_wr_valid = commit && !rst;
  assign bus.lb_in_weights   = commit ? {{(BUS_W - IMG_W){1'b0}}, shadow} : bus.lk_data;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_data        = res_data_q;
  assign bus.lut_gen         = gen_q;
`ifdef LUT_CFG_CHECK_EN
  assign bus.cfg_err         = err_q;
`else
  assign bus.cfg_err         = 1'b0;
`endif
endmodule

// File: tb/tb_lut_cfg_sched.sv
// Randomized bench for lut_cfg_sched with a lut_bank model and an image/table reference.
`timescale 1ns/1ps
module tb_lut_cfg_sched;
  import lut_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_cfg_sched_if bus_if();

  lut_cfg_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // lut_bank model: lane n indexes LUT n/64; table loads on the update strobes.
  logic [IMG_W-1:0] bank_tbl = '0;
  always @(posedge clk) begin
    if (bus_if.lb_cfg_update && bus_if.lb_lut_wr_valid)
      bank_tbl <= bus_if.lb_in_weights[IMG_W-1:0];
  end
  always_comb begin
    bus_if.lb_out_weights = '0;
    for (int n = 0; n < BUS_W/4; n++)
      bus_if.lb_out_weights[4*n +: 4] = bank_tbl[(n/64)*64 + 4*int'(bus_if.lb_in_weights[4*n +: 4]) +: 4];
  end

  // Reference: committed table as LUT x entry, image as received words.
  logic [3:0]       m_tab [NUM_LUTS][LUT_DEPTH];
  logic [CFG_W-1:0] m_img [WORDS];
  logic [BUS_W-1:0] m_exp;
  logic [BUS_W-1:0] zero_bus = '0;
  logic [7:0]       m_gen;
  logic             m_rdy, m_rv, m_commit, m_err, m_chk_zero;
  int               m_words;

  initial begin
    for (int i = 0; i < NUM_LUTS; i++)
      for (int j = 0; j < LUT_DEPTH; j++) m_tab[i][j] = 4'h0;
  end

  function automatic logic [BUS_W-1:0] ref_lookup(input logic [BUS_W-1:0] idx);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int n = 0; n < BUS_W/4; n++) r[4*n +: 4] = m_tab[n/64][idx[4*n +: 4]];
    return r;
  endfunction

  function automatic int first_diff(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
    for (int c = 0; c < BUS_W/64; c++)
      if (a[64*c +: 64] !== b[64*c +: 64]) return c;
    return 0;
  endfunction

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] r;
    for (int w = 0; w < BUS_W/32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    logic exp_lk, cfg_acc, lk_acc, res_fire, bad;
    int   k, n;
    if (rst) begin
      m_rdy = 0; m_rv = 0; m_commit = 0; m_words = 0;
      m_gen = 0; m_err = 0; m_chk_zero = 1;
    end else begin
      exp_lk = !m_commit && (!m_rv || bus_if.res_ready);
      check_val("cfg_ready", 64'(bus_if.cfg_ready), 64'(m_rdy && !m_commit));
      check_val("lk_ready", 64'(bus_if.lk_ready), 64'(exp_lk));
      check_val("cfg_update", 64'(bus_if.lb_cfg_update), 64'(m_commit));
      check_val("lut_wr_valid", 64'(bus_if.lb_lut_wr_valid), 64'(m_commit));
      check_val("res_valid", 64'(bus_if.res_valid), 64'(m_rv));
      if (m_rv) begin
        k = first_diff(bus_if.res_data, m_exp);
        check_val("res_data", bus_if.res_data[64*k +: 64], m_exp[64*k +: 64]);
      end else if (m_chk_zero) begin
        k = first_diff(bus_if.res_data, zero_bus);
        check_val("res_data_rst", bus_if.res_data[64*k +: 64], 64'd0);
      end
      check_val("lut_gen", 64'(bus_if.lut_gen), 64'(m_gen));
      check_val("cfg_err", 64'(bus_if.cfg_err), 64'(m_err));

      cfg_acc  = bus_if.cfg_valid && m_rdy && !m_commit;
      lk_acc   = bus_if.lk_valid && exp_lk;
      res_fire = m_rv && bus_if.res_ready;

      if (m_commit) begin
        for (int i = 0; i < NUM_LUTS; i++)
          for (int j = 0; j < LUT_DEPTH; j++) begin
            n = i*LUT_DEPTH + j;
            m_tab[i][j] = m_img[n/8][4*(n%8) +: 4];
          end
        m_gen = m_gen + 8'd1;
      end
      m_commit = 0;

      if (lk_acc) begin
        m_exp = ref_lookup(bus_if.lk_data);
        m_rv = 1; m_chk_zero = 0;
      end else if (res_fire) begin
        m_rv = 0;
      end

      if (cfg_acc) begin
        m_img[m_words] = bus_if.cfg_data;
        bad = 0;
`ifdef LUT_CFG_CHECK_EN
        bad = bus_if.cfg_last && (m_words != WORDS-1);
        if (bad || (!bus_if.cfg_last && m_words == WORDS-1)) m_err = 1;
`endif
        if (bad) m_words = 0;
        else if (m_words == WORDS-1) begin m_words = 0; m_commit = 1; end
        else m_words++;
      end
      m_rdy = 1;
    end
  end

  task automatic send_cfg(input logic [31:0] d, input logic last, input int gap);
    logic acc;
    int   t = 0;
    bus_if.cfg_valid = 1'b1;
    bus_if.cfg_data  = d;
    bus_if.cfg_last  = last;
    forever begin
      @(negedge clk); acc = bus_if.cfg_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (++t > 100) begin check_val("cfg_timeout", 64'(acc), 64'd1); break; end
    end
    if (gap > 0) begin
      bus_if.cfg_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_lk(input logic [BUS_W-1:0] d, input int gap);
    logic acc;
    int   t = 0;
    bus_if.lk_valid = 1'b1;
    bus_if.lk_data  = d;
    forever begin
      @(negedge clk); acc = bus_if.lk_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (++t > 100) begin check_val("lk_timeout", 64'(acc), 64'd1); break; end
    end
    if (gap > 0) begin
      bus_if.lk_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  // mode 0: fixed alternating pattern, 1: random words
  task automatic send_image(input int mode, input int gap_max, input int nwords);
    logic [31:0] w;
    for (int k = 0; k < nwords; k++) begin
      if (mode == 0) w = (k % 2 == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
      else           w = $urandom;
      send_cfg(w, k == WORDS-1, $urandom_range(0, gap_max));
    end
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_if.cfg_valid = 1'b0;
    bus_if.lk_valid  = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  logic rr_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rr_rand) bus_if.res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BUS_W-1:0] all_a;
    bus_if.cfg_valid = 1'b0; bus_if.cfg_data = '0; bus_if.cfg_last = 1'b0;
    bus_if.lk_valid  = 1'b0; bus_if.lk_data  = '0; bus_if.res_ready = 1'b1;
    do_reset();
    idle(2);

    // identity image: LUT i entry j holds j
    send_image(0, 0, WORDS);
    idle(3);
    check_val("gen_first", 64'(bus_if.lut_gen), 64'd1);
    for (int n = 0; n < BUS_W/4; n++) all_a[4*n +: 4] = 4'hA;
    send_lk(all_a, 0);
    bus_if.lk_valid = 1'b0;
    @(negedge clk);
    check_val("lut_identity", bus_if.res_data[1023:960], 64'hAAAA_AAAA_AAAA_AAAA);
    idle(2);

    // back-to-back lookups spanning a commit
    fork
      send_image(1, 0, WORDS);
      begin
        repeat (40) send_lk(rand_bus(), 0);
        bus_if.lk_valid = 1'b0;
      end
    join
    idle(3);

    // random overlap with random backpressure
    rr_rand = 1'b1;
    repeat (4) begin
      fork
        send_image(1, 2, WORDS);
        begin
          repeat (60) send_lk(rand_bus(), $urandom_range(0, 1));
          bus_if.lk_valid = 1'b0;
        end
      join
      idle(2);
    end
    rr_rand = 1'b0;
    bus_if.res_ready = 1'b1;
    idle(3);

    // result stall: hold res_ready low for 5 cycles with a pending lookup
    bus_if.res_ready = 1'b0;
    send_lk(rand_bus(), 0);
    bus_if.lk_data = rand_bus();
    idle(5);
    bus_if.res_ready = 1'b1;
    send_lk(bus_if.lk_data, 1);
    idle(3);

`ifdef LUT_CFG_CHECK_EN
    for (int k = 0; k <= 10; k++) send_cfg($urandom, k == 10, 0);
    bus_if.cfg_valid = 1'b0; bus_if.cfg_last = 1'b0;
    idle(3);
    check_val("err_early_last", 64'(bus_if.cfg_err), 64'd1);
    send_image(1, 0, WORDS);
    idle(3);
    send_lk(rand_bus(), 1);
    idle(2);
`endif

    // reset mid-load discards the partial image
    send_image(1, 0, 20);
    do_reset();
    idle(3);
    send_image(0, 0, WORDS);
    idle(3);
    check_val("gen_after_rst", 64'(bus_if.lut_gen), 64'd1);
    send_lk(rand_bus(), 1);
    idle(2);

    // 255 more commits wrap the generation counter
    repeat (255) send_image(0, 0, WORDS);
    idle(3);
    check_val("gen_wrap", 64'(bus_if.lut_gen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
